// File: rtl/conv_pkg.sv
// Shared definitions for the KxK sequential MAC convolution block.
//   state_t : FSM states (IDLE, CALC, DONE)
//   clog2   : ceiling log2 of an unsigned value (clog2(1) = 0)
//   acc_w   : accumulator width that cannot overflow for TAPS products
//   ngrp    : number of LANES-wide groups needed to cover TAPS taps
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned taps);
    return 2 * dw + clog2(taps);
  endfunction

  function automatic int unsigned ngrp(input int unsigned taps, input int unsigned lanes);
    return (taps + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One DATA_W x DATA_W multiplier lane.
//   i_a, i_b : operands (two's complement when SIGNED != 0)
//   o_prod   : full-width 2*DATA_W product
module conv_mac_lane #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned SIGNED = 0
) (
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [2*DATA_W-1:0] o_prod
);

  localparam int unsigned PW = 2 * DATA_W;

  if (SIGNED != 0) begin : g_signed
    logic signed [PW-1:0] w_sa;
    logic signed [PW-1:0] w_sb;
    assign w_sa   = PW'($signed(i_a));
    assign w_sb   = PW'($signed(i_b));
    assign o_prod = PW'(w_sa * w_sb);
  end else begin : g_unsigned
    logic [PW-1:0] w_ua;
    logic [PW-1:0] w_ub;
    assign w_ua   = PW'(i_a);
    assign w_ub   = PW'(i_b);
    assign o_prod = PW'(w_ua * w_ub);
  end

endmodule

// File: rtl/conv_kxk_mac_seq.sv
// Sequential KxK window dot product: LANES taps are multiplied and
// accumulated per cycle over NGRP cycles.
//   clk, rst             : clock, synchronous active-high reset
//   in_data, kernel      : packed window / weights, tap i at [i*DATA_W +: DATA_W]
//   in_valid / in_ready  : input handshake (ready only in IDLE, low in reset)
//   out_data             : sum of all TAPS products, ACC_W bits
//   out_valid / out_ready: output handshake, result held until consumed
module conv_kxk_mac_seq
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned K      = 5,
  parameter int unsigned LANES  = 5,
  parameter int unsigned SIGNED = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [K*K*DATA_W-1:0]               in_data,
  input  logic [K*K*DATA_W-1:0]               kernel,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [acc_w(DATA_W, K*K)-1:0]       out_data,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int unsigned TAPS  = K * K;
  localparam int unsigned NGRP  = ngrp(TAPS, LANES);
  localparam int unsigned ACC_W = acc_w(DATA_W, TAPS);
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned GRP_W = (NGRP > 1) ? clog2(NGRP) : 1;
  // Mux depth is rounded up to a power of two so r_grp indexes it exactly;
  // the extra slots (and taps >= TAPS) are tied to zero.
  localparam int unsigned NSLOT = 1 << GRP_W;

  state_t                 r_state;
  state_t                 w_next;
  logic [TAPS*DATA_W-1:0] r_data;
  logic [TAPS*DATA_W-1:0] r_kern;
  logic [ACC_W-1:0]       r_acc;
  logic [ACC_W-1:0]       w_sum;
  logic [GRP_W-1:0]       r_grp;
  logic                   w_accept;
  logic                   w_last;

  logic [DATA_W-1:0] w_sel_d [LANES][NSLOT];
  logic [DATA_W-1:0] w_sel_k [LANES][NSLOT];
  logic [DATA_W-1:0] w_a     [LANES];
  logic [DATA_W-1:0] w_b     [LANES];
  logic [PW-1:0]     w_prod  [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
      if (s * LANES + l < TAPS) begin : g_tap
        assign w_sel_d[l][s] = r_data[(s*LANES+l)*DATA_W +: DATA_W];
        assign w_sel_k[l][s] = r_kern[(s*LANES+l)*DATA_W +: DATA_W];
      end else begin : g_pad
        assign w_sel_d[l][s] = '0;
        assign w_sel_k[l][s] = '0;
      end
    end
    assign w_a[l] = w_sel_d[l][r_grp];
    assign w_b[l] = w_sel_k[l][r_grp];

    conv_mac_lane #(
      .DATA_W(DATA_W),
      .SIGNED(SIGNED)
    ) u_lane (
      .i_a   (w_a[l]),
      .i_b   (w_b[l]),
      .o_prod(w_prod[l])
    );
  end

  // Lane products are extended to ACC_W according to operand signedness
  // and summed; synthesis balances this into an adder tree.
  always_comb begin
    w_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (SIGNED != 0) w_sum = w_sum + ACC_W'($signed(w_prod[l]));
      else             w_sum = w_sum + ACC_W'(w_prod[l]);
    end
  end

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_grp == GRP_W'(NGRP - 1));
  assign out_data = r_acc;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) w_next = CALC;
      end
      CALC: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_grp <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_kern <= kernel;
      r_acc  <= '0;
      r_grp  <= '0;
    end else if (r_state == CALC) begin
      r_acc <= r_acc + w_sum;
      r_grp <= r_grp + 1'b1;
    end
  end

endmodule

// File: doc/conv_kxk_mac_seq.md
CONV_KXK_MAC_SEQ -- requirements
Module: conv_kxk_mac_seq

Interface
REQ-001 Parameter DATA_W, default 6: operand width in bits, range 2..16.
REQ-002 Parameter K, default 5: kernel edge; the window holds K*K taps, range 1..7.
REQ-003 Parameter LANES, default 5: multipliers per cycle, range 1..K*K.
REQ-004 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-005 Derived constants: TAPS = K*K; NGRP = ceil(TAPS/LANES); ACC_W = 2*DATA_W + clog2(TAPS), which is 17 at defaults.
REQ-006 Port clk, input, 1 bit: the single clock, rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port in_data, input, TAPS*DATA_W bits: packed window; tap i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Port kernel, input, TAPS*DATA_W bits: packed weights, same tap layout as in_data.
REQ-010 Port in_valid, input, 1 bit: the in_data/kernel pair is valid.
REQ-011 Port in_ready, output, 1 bit: the block accepts a window this cycle.
REQ-012 Port out_data, output, ACC_W bits: sum of products over all TAPS taps.
REQ-013 Port out_valid, output, 1 bit: out_data is valid.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts out_data.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 IDLE SHALL drive in_ready=1 and out_valid=0.
REQ-017 An accept occurs when in_valid=1 and in_ready=1 in IDLE; the block SHALL then register in_data and kernel, clear the accumulator and group counter, and move to CALC.
REQ-018 In CALC, each cycle SHALL add the products of taps grp*LANES .. grp*LANES+LANES-1 to the accumulator and increment grp.
REQ-019 Taps with index >= TAPS SHALL contribute zero.
REQ-020 After group NGRP-1 the FSM SHALL go to DONE and assert out_valid=1 with the final sum.
REQ-021 Latency: out_valid SHALL rise exactly NGRP cycles after the accept edge (5 at defaults).
REQ-022 DONE SHALL hold out_data stable and out_valid high until out_ready=1, then return to IDLE on the next edge.
REQ-023 in_ready SHALL be 0 in CALC and DONE; in_valid in those states SHALL be ignored and nothing captured.
REQ-024 Changes on the in_data and kernel ports after accept SHALL NOT affect the result.
REQ-025 SIGNED=0: products and sum are unsigned and zero-extended to ACC_W.
REQ-026 SIGNED=1: operands, products and sum are two's complement and sign-extended to ACC_W.
REQ-027 ACC_W is sized so that no overflow is possible; no saturation SHALL be applied.
REQ-028 out_ready=1 in IDLE or CALC SHALL have no effect.

Reset
REQ-029 When rst=1 at a clk edge, the FSM SHALL go to IDLE, grp SHALL be 0 and the accumulator 0.
REQ-030 Output reset values: in_ready=0 while rst=1 and 1 after rst falls; out_valid=0; out_data=0.
REQ-031 Reset in CALC or DONE SHALL discard the window in progress without emitting a result.

Structure
REQ-032 A shared package conv_pkg SHALL hold the state enum (IDLE/CALC/DONE) and functions for clog2, ACC_W and NGRP.
REQ-033 A single sub-module, conv_mac_lane, SHALL compute one DATA_W x DATA_W product honoring SIGNED.
REQ-034 LANES instances of conv_mac_lane SHALL feed one adder tree into the accumulator.
REQ-035 The per-cycle tap selection SHALL be a mux on grp; no block is consumed per tap.

Verification
REQ-036 Defaults, all in_data=63 and all kernel=63, out_ready=1 -> out_data=99225, out_valid rising 5 cycles after accept, then one cycle in DONE.
REQ-037 Defaults, in_data[i]=i and kernel[i]=1 -> out_data=300; the input ports are scrambled during CALC and the result is unchanged.
REQ-038 SIGNED=1, DATA_W=6, all in_data=-32 and all kernel=31 -> out_data=-24800 sign-extended in 17 bits.
REQ-039 LANES=4 (NGRP=7), kernel one-hot at tap 24 with value 2, in_data[24]=10 -> out_data=20 after 7 cycles, confirming the padded lanes are zero.
REQ-040 out_ready held low for 10 cycles in DONE -> out_valid and out_data stable throughout, in_ready=0, and an in_valid pulse is not captured.
REQ-041 rst asserted on the 3rd CALC cycle -> next cycle in IDLE with out_valid=0 and out_data=0; a new accept then yields the correct sum for the new window only.
